addr_bus_arbiter: RTL and testbench

Parametrised successor to the two-input address bus mux. It arbitrates the shared address bus between one PC fetch channel and N_DATA data-access channels, with a per-channel req/gnt handshake. Arbitration is round-robin and the address bus output is registered. The block sits between the fetch/load-store units and memory, driving address_bus and recording which channel owns the bus.

---
 rtl/addr_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_addr_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_bus_arbiter.sv
// Round-robin arbiter for the shared address bus: one PC fetch channel plus N_DATA data channels.
// Optional hold-time preemption is built when ADDR_ARB_TIMEOUT_EN is defined.
module addr_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int PC_W    = 8,
  parameter int N_DATA  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_req,
  input  logic [PC_W-1:0]          pc_address,
  input  logic [N_DATA-1:0]        dat_req,
  input  logic [N_DATA*ADDR_W-1:0] dat_addr,
  output logic                     pc_gnt,
  output logic [N_DATA-1:0]        dat_gnt,
  output logic [ADDR_W-1:0]        address_bus,
  output logic                     bus_valid,
  output logic [2:0]               owner
);

  localparam int N_CH = N_DATA + 1;
  localparam logic [2:0] LAST_DATA = 3'(N_DATA);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  generate
    if (PC_W > ADDR_W || N_DATA < 1 || N_DATA > 7 || TIMEOUT < 1) begin : g_bad_params
      $error("addr_bus_arbiter: illegal parameter combination");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [2:0]        owner_reg, owner_next;
  logic [2:0]        rr_last_reg, rr_last_next;
  logic [N_CH-1:0]   gnt_reg, gnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  // Requests and addresses are padded to 8 channels so a 3-bit index always fits.
  logic [7:0]        req8;
  logic [ADDR_W-1:0] addr_sel [8];
  logic [7:0]        owner_mask8;
  logic [7:0]        other_req;
  logic              owner_req;
  logic              preempt;
  logic              grant_new;
  logic [2:0]        grant_idx;

  assign req8[0]     = pc_req;
  assign addr_sel[0] = ADDR_W'(pc_address);

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_chan
      if (gi <= N_DATA) begin : g_used
        assign req8[gi]     = dat_req[gi-1];
        assign addr_sel[gi] = dat_addr[(gi-1)*ADDR_W +: ADDR_W];
      end else begin : g_unused
        assign req8[gi]     = 1'b0;
        assign addr_sel[gi] = '0;
      end
    end
  endgenerate

  assign owner_mask8 = 8'd1 << owner_reg;
  assign owner_req   = |(req8 & owner_mask8);
  assign other_req   = req8 & ~owner_mask8;

  // First requester after ptr, wrapping over the N_CH channels; ptr itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] r);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = 3'((int'(ptr) + k) % N_CH);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef ADDR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  assign preempt = (state_reg == OWN) && (hold_cnt_reg == CNT_W'(TIMEOUT)) && (|other_req);

  // Counter is 1 on the first owned cycle and saturates at TIMEOUT.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (grant_new) begin
      hold_cnt_next = CNT_W'(1);
    end else if (state_reg == OWN && hold_cnt_reg != CNT_W'(TIMEOUT)) begin
      hold_cnt_next = hold_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    rr_last_next = rr_last_reg;
    gnt_next     = gnt_reg;
    addr_next    = addr_reg;
    grant_new    = 1'b0;
    grant_idx    = owner_reg;

    case (state_reg)
      IDLE: begin
        if (|req8) begin
          grant_new = 1'b1;
          grant_idx = rr_pick(rr_last_reg, req8);
        end else begin
          gnt_next  = '0;
          addr_next = '0;
        end
      end
      OWN: begin
        if (owner_req && !preempt) begin
          addr_next = addr_sel[owner_reg];
        end else if (|other_req) begin
          // Hand over directly to the next requester; the old owner is excluded.
          grant_new = 1'b1;
          grant_idx = rr_pick(owner_reg, other_req);
        end else begin
          state_next = IDLE;
          gnt_next   = '0;
          addr_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (grant_new) begin
      state_next   = OWN;
      owner_next   = grant_idx;
      rr_last_next = grant_idx;
      addr_next    = addr_sel[grant_idx];
      for (int i = 0; i < N_CH; i++) begin
        gnt_next[i] = (grant_idx == 3'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      rr_last_reg <= LAST_DATA;
      gnt_reg     <= '0;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_last_reg <= rr_last_next;
      gnt_reg     <= gnt_next;
      addr_reg    <= addr_next;
    end
  end

  assign pc_gnt      = gnt_reg[0];
  assign dat_gnt     = gnt_reg[N_CH-1:1];
  assign address_bus = addr_reg;
  assign bus_valid   = (state_reg == OWN);
  assign owner       = owner_reg;

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: randomized traffic against a channel-level reference model,
// plus directed sequences with hand-computed expectations.
module tb_addr_bus_arbiter;

  localparam int ADDR_W  = 16;
  localparam int PC_W    = 8;
  localparam int N_DATA  = 2;
  localparam int TIMEOUT = 16;
  localparam int N_CH    = N_DATA + 1;

  logic                     clk;
  logic                     reset;
  logic                     pc_req;
  logic [PC_W-1:0]          pc_address;
  logic [N_DATA-1:0]        dat_req;
  logic [N_DATA*ADDR_W-1:0] dat_addr;
  logic                     pc_gnt;
  logic [N_DATA-1:0]        dat_gnt;
  logic [ADDR_W-1:0]        address_bus;
  logic                     bus_valid;
  logic [2:0]               owner;

  addr_bus_arbiter #(
    .ADDR_W(ADDR_W), .PC_W(PC_W), .N_DATA(N_DATA), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .pc_req(pc_req), .pc_address(pc_address),
    .dat_req(dat_req), .dat_addr(dat_addr), .pc_gnt(pc_gnt), .dat_gnt(dat_gnt),
    .address_bus(address_bus), .bus_valid(bus_valid), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference model: who owns the bus, which channel was granted last, how long it has held.
  bit                m_valid;
  int                m_owner;
  int                m_last;
  int                m_hold;
  logic [ADDR_W-1:0] m_addr;

  always @(posedge clk) begin
    bit                r [N_CH];
    logic [ADDR_W-1:0] a [N_CH];
    bit                others;
    bit                cut;
    int                start;
    int                pick;
    int                idx;
    r[0] = pc_req;
    a[0] = ADDR_W'(pc_address);
    for (int i = 0; i < N_DATA; i++) begin
      r[i+1] = dat_req[i];
      a[i+1] = dat_addr[i*ADDR_W +: ADDR_W];
    end
    if (reset) begin
      m_valid = 0; m_owner = 0; m_last = N_DATA; m_hold = 0; m_addr = '0;
    end else begin
      others = 0;
      for (int i = 0; i < N_CH; i++) if (m_valid && i != m_owner && r[i]) others = 1;
      cut = 0;
`ifdef ADDR_ARB_TIMEOUT_EN
      cut = (m_hold == TIMEOUT) && others;
`endif
      if (m_valid && r[m_owner] && !cut) begin
        m_addr = a[m_owner];
        if (m_hold < TIMEOUT) m_hold = m_hold + 1;
      end else begin
        start = m_valid ? m_owner : m_last;
        pick = -1;
        for (int k = 1; k <= N_CH; k++) begin
          idx = (start + k) % N_CH;
          if (pick < 0 && r[idx] && !(m_valid && idx == m_owner)) pick = idx;
        end
        if (pick >= 0) begin
          m_valid = 1; m_owner = pick; m_last = pick; m_hold = 1; m_addr = a[pick];
        end else begin
          m_valid = 0; m_addr = '0;
        end
      end
    end
  end

  // Literal expectations written by the directed sequences.
  bit                pin_en = 0;
  bit                pin_rst;
  bit                pin_valid;
  int                pin_owner;
  logic [N_CH-1:0]   pin_gnt;
  logic [ADDR_W-1:0] pin_addr;
  string             pin_name;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N_CH-1:0] dut_gnt;
    logic [N_CH-1:0] exp_gnt;
    if (chk_en) begin
      dut_gnt = {dat_gnt, pc_gnt};
      exp_gnt = '0;
      if (m_valid) exp_gnt[m_owner] = 1'b1;
      cmp("model/valid", bus_valid, m_valid);
      cmp("model/gnt", dut_gnt, exp_gnt);
      cmp("model/addr", address_bus, m_addr);
      if (m_valid) cmp("model/owner", owner, m_owner);
      cmp("onehot", ($countones(dut_gnt) <= 1), 1);
      if (pin_en) begin
        cmp({pin_name, "/dut_valid"}, bus_valid, pin_valid);
        cmp({pin_name, "/dut_gnt"}, dut_gnt, pin_gnt);
        cmp({pin_name, "/dut_addr"}, address_bus, pin_addr);
        cmp({pin_name, "/ref_valid"}, m_valid, pin_valid);
        cmp({pin_name, "/ref_addr"}, m_addr, pin_addr);
        if (pin_valid || pin_rst) begin
          cmp({pin_name, "/dut_owner"}, owner, pin_owner);
          cmp({pin_name, "/ref_owner"}, m_owner, pin_owner);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    pin_en = 0;
  endtask

  task automatic expect_own(input string nm, input int own, input logic [ADDR_W-1:0] ad);
    pin_name = nm; pin_rst = 0; pin_valid = 1; pin_owner = own;
    pin_gnt = N_CH'(1) << own; pin_addr = ad; pin_en = 1;
  endtask

  task automatic expect_zero(input string nm, input bit is_rst);
    pin_name = nm; pin_rst = is_rst; pin_valid = 0; pin_owner = 0;
    pin_gnt = '0; pin_addr = '0; pin_en = 1;
  endtask

  task automatic rand_reqs();
    pc_req  = 1'($urandom);
    dat_req = N_DATA'($urandom);
  endtask

  initial begin
    int  p_flip;
    reset = 1; pc_req = 0; dat_req = '0; pc_address = '0; dat_addr = '0;

    // Reset with random requests, then idle.
    tick(); chk_en = 1; expect_zero("rst0", 1); rand_reqs();
    tick(); expect_zero("rst1", 1); rand_reqs();
    tick(); expect_zero("rst2", 1); reset = 0; pc_req = 0; dat_req = '0;
    tick(); expect_zero("idle0", 0);
    tick(); expect_zero("idle1", 0);

    // PC grant and address tracking.
    pc_req = 1; pc_address = 8'd1;
    tick(); expect_own("pc_grant", 0, 16'd1);
    pc_address = 8'd5;
    tick(); expect_own("pc_track", 0, 16'd5);

    // Handover to ch1 with no bubble.
    dat_req = 2'b01; dat_addr[15:0] = 16'd200; pc_req = 0;
    tick(); expect_own("handover", 1, 16'd200);
    dat_req = 2'b00;
    tick(); expect_zero("release", 0);

    // Round-robin order from reset: PC, ch1, ch2, PC.
    reset = 1;
    tick(); expect_zero("rr_rst", 1);
    reset = 0; pc_req = 1; dat_req = 2'b11;
    pc_address = 8'h10; dat_addr = {16'h2222, 16'h1111};
    tick(); expect_own("rr_pc", 0, 16'h0010);
    pc_req = 0;
    tick(); expect_own("rr_ch1", 1, 16'h1111);
    dat_req[0] = 0; pc_req = 1;
    tick(); expect_own("rr_ch2", 2, 16'h2222);
    dat_req[1] = 0;
    tick(); expect_own("rr_pc2", 0, 16'h0010);
    pc_req = 0;
    tick(); expect_zero("rr_idle", 0);

    // Reset pulse mid-grant with ch2 still requesting.
    dat_req = 2'b10; dat_addr[31:16] = 16'hBEEF;
    tick(); expect_own("ch2_own", 2, 16'hBEEF);
    reset = 1;
    tick(); expect_zero("mid_rst", 1);
    reset = 0;
    tick(); expect_own("post_rst", 2, 16'hBEEF);
    dat_req = 2'b00;
    tick(); expect_zero("post_rst_idle", 0);

    // Long PC hold with ch1 pending.
    pc_req = 1; pc_address = 8'h33; dat_req = 2'b01; dat_addr[15:0] = 16'h0A0A;
`ifdef ADDR_ARB_TIMEOUT_EN
    for (int j = 0; j < 16; j++) begin
      tick(); expect_own("to_pc_hold", 0, 16'h0033);
    end
    tick(); expect_own("to_preempt", 1, 16'h0A0A);
`else
    for (int j = 0; j < 110; j++) begin
      tick(); expect_own("no_to_hold", 0, 16'h0033);
    end
`endif
    pc_req = 0; dat_req = '0;
    tick();
    tick(); expect_zero("to_idle", 0);

    // Randomized traffic, alternating busy-toggling and long-hold phases.
    for (int c = 0; c < 4000; c++) begin
      p_flip = ((c / 500) % 2 == 0) ? 30 : 3;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < p_flip) pc_req = ~pc_req;
      for (int i = 0; i < N_DATA; i++)
        if ($urandom_range(0, 99) < p_flip) dat_req[i] = ~dat_req[i];
      pc_address = PC_W'($urandom);
      for (int i = 0; i < N_DATA; i++) dat_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      tick();
    end
    reset = 0; pc_req = 0; dat_req = '0;
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
